// File: rtl/db15_joy_responder.sv
// Adapter-side model of the DB15 two-player shift-register joystick interface.
// Answers asynchronous joy_load/joy_clk strobes with a 32-bit active-low frame.
module db15_joy_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        joy_load,
    input  logic        joy_clk,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    output logic        joy_data,
    output logic        frame_done,
    output logic [5:0]  bit_count,
    output logic        link_active
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] load_sync_p0;
    logic [SYNC_STAGES-1:0] clk_sync_p0;
    logic                   clk_dly_p0;
    logic                   load_s;
    logic                   clk_s;
    logic                   clk_rise;
    logic                   shift_en;
    logic                   strobe;

    logic [31:0]            sr_p1;
    logic                   done_p1;
    logic [CNT_W-1:0]       idle_cnt;
    logic                   seen_strobe;

    // Stage p0: synchronisers, preset high so leaving reset never fakes an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            load_sync_p0 <= '1;
            clk_sync_p0  <= '1;
            clk_dly_p0   <= 1'b1;
        end else begin
            load_sync_p0 <= {load_sync_p0[SYNC_STAGES-2:0], joy_load};
            clk_sync_p0  <= {clk_sync_p0[SYNC_STAGES-2:0], joy_clk};
            clk_dly_p0   <= clk_s;
        end
    end

    assign load_s   = load_sync_p0[SYNC_STAGES-1];
    assign clk_s    = clk_sync_p0[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_dly_p0;
    assign shift_en = load_s & clk_rise & (bit_count < 6'd32);
    assign strobe   = ~load_s | clk_rise;

    // Stage p1: shift register holds the frame inverted, bit 0 next on the wire
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_p1     <= '1;
            bit_count <= 6'd0;
            done_p1   <= 1'b0;
        end else if (!load_s) begin
            sr_p1     <= ~{joystick2, joystick1};
            bit_count <= 6'd0;
            done_p1   <= 1'b0;
        end else if (shift_en) begin
            sr_p1     <= {1'b1, sr_p1[31:1]};
            bit_count <= bit_count + 6'd1;
            done_p1   <= (bit_count == 6'd31);
        end else begin
            done_p1   <= 1'b0;
        end
    end

    // Stage p2: registered outputs, frame_done aligned with the idle level on joy_data
    always_ff @(posedge clk) begin
        if (reset) begin
            joy_data   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            joy_data   <= sr_p1[0];
            frame_done <= done_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt    <= '0;
            seen_strobe <= 1'b0;
        end else if (strobe) begin
            idle_cnt    <= '0;
            seen_strobe <= 1'b1;
        end else if (idle_cnt < TIMEOUT_MAX) begin
            idle_cnt    <= idle_cnt + CNT_W'(1);
        end
    end

    assign link_active = seen_strobe & (idle_cnt < TIMEOUT_MAX);

endmodule

// File: tb/tb_db15_joy_responder.sv
// Scoreboard bench: a reader model drives strobes, a monitor checks each finished frame.
module tb_db15_joy_responder;
    localparam int SYNC = 2;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        joy_load = 1'b1;
    logic        joy_clk = 1'b0;
    logic [15:0] joystick1 = 16'h0;
    logic [15:0] joystick2 = 16'h0;
    logic        joy_data;
    logic        frame_done;
    logic [5:0]  bit_count;
    logic        link_active;

    db15_joy_responder #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .joy_load(joy_load), .joy_clk(joy_clk),
        .joystick1(joystick1), .joystick2(joystick2), .joy_data(joy_data),
        .frame_done(frame_done), .bit_count(bit_count), .link_active(link_active)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    int          push_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cap_frame = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reader: pressed = ~joy_data; frame bits 0..15 from joystick1, 16..31 from joystick2
    task automatic run_frame(input int h, input int nclk, input bit mutate);
        logic [31:0] snap;
        joy_load = 1'b0;
        cyc(h);
        snap = {joystick2, joystick1};
        joy_load = 1'b1;
        cyc(h);
        if (nclk >= 32) begin
            exp_q.push_back(snap);
            push_cnt++;
        end
        for (int n = 0; n < nclk; n++) begin
            if (n < 32) cap_frame[n] = ~joy_data;
            else begin
                check("overclock_data", {31'b0, joy_data}, 32'd1);
                check("overclock_count", {26'b0, bit_count}, 32'd32);
            end
            joy_clk = 1'b1;
            cyc(h);
            if (mutate && n == 0) begin
                joystick1 = 16'($urandom);
                joystick2 = 16'($urandom);
            end
            joy_clk = 1'b0;
            cyc(h);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, {31'b0, joy_data}, 32'd1);
        check({tag, "_done"}, {31'b0, frame_done}, 32'd0);
        check({tag, "_count"}, {26'b0, bit_count}, 32'd0);
        check({tag, "_link"}, {31'b0, link_active}, 32'd0);
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && frame_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_frame_done: pulse seen at bit_count %0d, none required", bit_count);
            end else begin
                e = exp_q.pop_front();
                check("frame_data", cap_frame, e);
                check("bit_count_at_done", {26'b0, bit_count}, 32'd32);
                check("link_at_done", {31'b0, link_active}, 32'd1);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int d0;
        int h;
        int nclk;

        reset = 1'b1;
        cyc(3);
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cyc(10);
            check("idle_data", {31'b0, joy_data}, 32'd1);
            check("idle_count", {26'b0, bit_count}, 32'd0);
            check("idle_link", {31'b0, link_active}, 32'd0);
        end

        joystick1 = 16'h0011;
        joystick2 = 16'h8002;
        d0 = done_cnt;
        run_frame(8, 40, 1'b0);
        check("directed_done_once", done_cnt - d0, 32'd1);
        check("directed_bit_count", {26'b0, bit_count}, 32'd32);
        check("directed_frame", cap_frame, 32'h80020011);

        joystick1 = 16'hFFFE;
        run_frame(8, 10, 1'b0);
        check("abort_count", {26'b0, bit_count}, 32'd10);
        joystick1 = 16'h0001;
        joy_load = 1'b0;
        cyc(4);
        check("reload_data", {31'b0, joy_data}, 32'd0);
        check("reload_count", {26'b0, bit_count}, 32'd0);
        cyc(8);
        joy_load = 1'b1;
        cyc(8);

        joy_load = 1'b0;
        cyc(8);
        for (int i = 0; i < 5; i++) begin
            joystick1[0] = ~joystick1[0];
            joy_clk = 1'b1;
            cyc(6);
            check("held_count", {26'b0, bit_count}, 32'd0);
            check("held_data", {31'b0, joy_data}, {31'b0, ~joystick1[0]});
            joy_clk = 1'b0;
            cyc(6);
        end
        joy_load = 1'b1;
        cyc(8);

        for (int f = 0; f < 14; f++) begin
            h = $urandom_range(SYNC + 3, 10);
            nclk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : $urandom_range(32, 36);
            joystick1 = 16'($urandom);
            joystick2 = 16'($urandom);
            run_frame(h, nclk, 1'b1);
        end

        joy_load = 1'b0;
        cyc(6);
        joy_load = 1'b1;
        k = 0;
        while (link_active && k < 300) begin
            cyc(1);
            k++;
        end
        check("timeout_cycles", k, TMO + SYNC);
        joy_clk = 1'b1;
        cyc(4);
        check("link_back", {31'b0, link_active}, 32'd1);
        joy_clk = 1'b0;
        cyc(6);

        joystick1 = 16'($urandom);
        joystick2 = 16'($urandom);
        run_frame(6, 17, 1'b0);
        check("pre_reset_count", {26'b0, bit_count}, 32'd17);
        reset = 1'b1;
        cyc(1);
        check_reset_outputs("midreset");
        reset = 1'b0;
        cyc(5);

        joystick1 = 16'($urandom);
        joystick2 = 16'($urandom);
        run_frame(7, 32, 1'b0);
        cyc(10);

        check("frame_done_total", done_cnt, push_cnt);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
